uart_receiver: RTL and testbench

Serial-to-parallel UART receiver: the receive end of the UART link whose transmitter takes one word from the TX FIFO and shifts it out LSB-first. It synchronises the asynchronous `rx` line and oversamples it on the shared baud-rate generator's `sample_tick` (16 ticks per bit). It recovers one start bit, DBITS data bits and one stop bit, and presents each received word to the RX FIFO with a one-cycle `rx_done` strobe plus a framing-error flag.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_receiver_if.sv | 14 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_receiver.sv | 148 ++++++++++++++
 tb/tb_uart_receiver.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the oversampling ratio.
package uart_pkg;

  // Oversampling ratio of the shared baud-rate generator (sample ticks per bit).
  localparam int unsigned OVERSAMPLE = 16;

  // Encodings are shared with the transmitter.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-RX-FIFO handoff: received word, write strobe and framing-error flag.
interface uart_receiver_if #(
  parameter int unsigned DBITS = 8
);

  logic [DBITS-1:0] data_out;
  logic             rx_done;
  logic             frame_err;

  // Receiver drives the word; the FIFO side consumes it.
  modport master (output data_out, output rx_done, output frame_err);
  modport slave  (input data_out, input rx_done, input frame_err);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift toward the clock domain; first stage may go metastable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronises rx, oversamples it on sample_tick, recovers start/data/stop
// and hands each word to the RX FIFO with a one-cycle rx_done strobe.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DBITS   = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  sample_tick,
  uart_receiver_if.master       rx_bus,
  output logic [1:0]            state_out
);

  // Tick index at the middle of the start bit, at the end of a data bit and of the stop bit.
  localparam logic [3:0] START_MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] BIT_END   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] STOP_END  = 4'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBITS - 1);

  logic rx_s;

  uart_state_e      state_q, state_d;
  logic [3:0]       tick_q, tick_d;
  logic [2:0]       nbits_q, nbits_d;
  logic [DBITS-1:0] shreg_q, shreg_d;
  logic             armed_q, armed_d;
  logic [DBITS-1:0] data_out_q, data_out_d;
  logic             rx_done_q, rx_done_d;
  logic             frame_err_q, frame_err_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk_100MHz),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // State and datapath registers; outputs are registered too.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      nbits_q     <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b1;
      data_out_q  <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      nbits_q     <= nbits_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      data_out_q  <= data_out_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: sample_tick only acts on the current state, never on the one entered.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    nbits_d     = nbits_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    data_out_d  = data_out_q;
    frame_err_d = frame_err_q;
    rx_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // armed blocks restarting on a line that was already low after a break.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (sample_tick) begin
          if (tick_q == START_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              nbits_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (sample_tick) begin
          if (tick_q == BIT_END) begin
            // Shift in from the top so the first bit on the line ends up in the LSB.
            shreg_d = DBITS'({rx_s, shreg_q} >> 1);
            tick_d  = '0;
            if (nbits_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              nbits_d = nbits_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (sample_tick) begin
          if (tick_q == STOP_END) begin
            state_d     = IDLE;
            data_out_d  = shreg_q;
            frame_err_d = ~rx_s;
            rx_done_d   = 1'b1;
            if (!rx_s) begin
              armed_d = 1'b0;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_bus.data_out  = data_out_q;
  assign rx_bus.rx_done   = rx_done_q;
  assign rx_bus.frame_err = frame_err_q;
  assign state_out        = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: default 8-bit instance plus a 7-bit instance.
module tb_uart_receiver;

  localparam int TPS = 4;  // clocks per sample_tick

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         len;
  } rec_t;

  logic       clk_100MHz;
  logic       reset_n;
  logic       sample_tick;
  logic       rx8;
  logic       rx7;
  logic [1:0] state8;
  logic [1:0] state7;

  int         tdiv;
  int         checks;
  int         passed;
  int         failed;
  int         wide8;
  int         wide7;
  int         last_run8;
  rec_t       q8[$];
  rec_t       q7[$];

  uart_receiver_if #(.DBITS(8)) bus8 ();
  uart_receiver_if #(.DBITS(7)) bus7 ();

  uart_receiver #(
    .DBITS   (8),
    .SB_TICK (16)
  ) dut8 (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .rx          (rx8),
    .sample_tick (sample_tick),
    .rx_bus      (bus8),
    .state_out   (state8)
  );

  uart_receiver #(
    .DBITS   (7),
    .SB_TICK (16)
  ) dut7 (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .rx          (rx7),
    .sample_tick (sample_tick),
    .rx_bus      (bus7),
    .state_out   (state7)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Baud generator stand-in: one-clock pulse every TPS clocks, changed on the falling edge.
  initial begin
    tdiv = 0;
    sample_tick = 1'b0;
  end
  always @(negedge clk_100MHz) begin
    sample_tick <= (tdiv == 0);
    tdiv        <= (tdiv == TPS - 1) ? 0 : tdiv + 1;
  end

  // Record every strobed word with the number of ticks consumed since leaving idle.
  initial begin : mon8
    logic [1:0] ps;
    logic       pd;
    int         c;
    ps = 2'd0; pd = 1'b0; c = 0; wide8 = 0; last_run8 = 0;
    forever begin
      @(negedge clk_100MHz);
      if (ps != 2'd0 && sample_tick) c++;
      if (bus8.rx_done) q8.push_back('{data: bus8.data_out, ferr: bus8.frame_err, len: c});
      if (bus8.rx_done && pd) wide8++;
      if (state8 == 2'd0) begin
        if (c != 0) last_run8 = c;
        c = 0;
      end
      ps = state8;
      pd = bus8.rx_done;
    end
  end

  initial begin : mon7
    logic [1:0] ps;
    logic       pd;
    int         c;
    ps = 2'd0; pd = 1'b0; c = 0; wide7 = 0;
    forever begin
      @(negedge clk_100MHz);
      if (ps != 2'd0 && sample_tick) c++;
      if (bus7.rx_done) q7.push_back('{data: {1'b0, bus7.data_out}, ferr: bus7.frame_err, len: c});
      if (bus7.rx_done && pd) wide7++;
      if (state7 == 2'd0) c = 0;
      ps = state7;
      pd = bus7.rx_done;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TPS) @(negedge clk_100MHz);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 7) rx7 = v;
    else rx8 = v;
  endtask

  // One frame, LSB first, 16 ticks per bit; line returns high afterwards.
  task automatic send_frame(input int which, input logic [7:0] data, input int nb,
                            input logic stop_bit);
    set_rx(which, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      set_rx(which, data[i]);
      wait_ticks(16);
    end
    set_rx(which, stop_bit);
    wait_ticks(16);
    set_rx(which, 1'b1);
  endtask

  initial begin
    checks = 0; passed = 0; failed = 0;
    reset_n = 1'b0;
    rx8 = 1'b1;
    rx7 = 1'b1;
    repeat (3) @(negedge clk_100MHz);

    // Reset state
    check("reset_state", 32'(state8), 32'h0);
    check("reset_rx_done", 32'(bus8.rx_done), 32'h0);
    check("reset_data_out", 32'(bus8.data_out), 32'h0);
    check("reset_frame_err", 32'(bus8.frame_err), 32'h0);
    reset_n = 1'b1;
    wait_ticks(4);

    // Single byte 0x55
    q8.delete();
    send_frame(8, 8'h55, 8, 1'b1);
    wait_ticks(8);
    check("single_count", 32'(q8.size()), 32'd1);
    if (q8.size() == 1) begin
      check("single_data", 32'(q8[0].data), 32'h55);
      check("single_ferr", 32'(q8[0].ferr), 32'h0);
      check("single_len", 32'(q8[0].len), 32'd152);
    end
    check("single_idle", 32'(state8), 32'h0);
    check("single_hold", 32'(bus8.data_out), 32'h55);

    // Start detection latency and glitch rejection
    q8.delete();
    rx8 = 1'b0;
    @(posedge clk_100MHz);
    @(posedge clk_100MHz);
    #1;
    check("start_edge2", 32'(state8), 32'h0);
    @(posedge clk_100MHz);
    #1;
    check("start_edge3", 32'(state8), 32'h1);
    wait_ticks(4);
    rx8 = 1'b1;
    wait_ticks(12);
    check("glitch_no_strobe", 32'(q8.size()), 32'd0);
    check("glitch_ticks", 32'(last_run8), 32'd8);
    check("glitch_idle", 32'(state8), 32'h0);
    check("glitch_hold", 32'(bus8.data_out), 32'h55);

    // Back-to-back 0xA3, 0x0F
    q8.delete();
    send_frame(8, 8'hA3, 8, 1'b1);
    send_frame(8, 8'h0F, 8, 1'b1);
    wait_ticks(8);
    check("b2b_count", 32'(q8.size()), 32'd2);
    if (q8.size() == 2) begin
      check("b2b_data0", 32'(q8[0].data), 32'hA3);
      check("b2b_data1", 32'(q8[1].data), 32'h0F);
      check("b2b_ferr0", 32'(q8[0].ferr), 32'h0);
      check("b2b_ferr1", 32'(q8[1].ferr), 32'h0);
      check("b2b_len1", 32'(q8[1].len), 32'd152);
    end
    check("b2b_strobe_width", 32'(wide8), 32'd0);

    // Framing error, break, recovery
    q8.delete();
    send_frame(8, 8'hC4, 8, 1'b0);
    wait_ticks(16);
    rx8 = 1'b0;
    wait_ticks(480);
    rx8 = 1'b1;
    wait_ticks(16);
    send_frame(8, 8'h3C, 8, 1'b1);
    wait_ticks(8);
    check("ferr_count", 32'(q8.size()), 32'd3);
    if (q8.size() == 3) begin
      check("ferr_data0", 32'(q8[0].data), 32'hC4);
      check("ferr_flag0", 32'(q8[0].ferr), 32'h1);
      check("break_data", 32'(q8[1].data), 32'h00);
      check("break_flag", 32'(q8[1].ferr), 32'h1);
      check("recover_data", 32'(q8[2].data), 32'h3C);
      check("recover_flag", 32'(q8[2].ferr), 32'h0);
    end
    check("recover_out", 32'(bus8.frame_err), 32'h0);

    // Reset during data bit 4 of 0xFF
    q8.delete();
    rx8 = 1'b0;
    wait_ticks(16);
    rx8 = 1'b1;
    wait_ticks(72);
    check("midreset_in_data", 32'(state8), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_state", 32'(state8), 32'h0);
    check("midreset_data", 32'(bus8.data_out), 32'h0);
    check("midreset_done", 32'(bus8.rx_done), 32'h0);
    repeat (2) @(negedge clk_100MHz);
    reset_n = 1'b1;
    wait_ticks(100);
    check("midreset_no_strobe", 32'(q8.size()), 32'd0);
    send_frame(8, 8'h81, 8, 1'b1);
    wait_ticks(8);
    check("after_reset_count", 32'(q8.size()), 32'd1);
    if (q8.size() == 1) begin
      check("after_reset_data", 32'(q8[0].data), 32'h81);
      check("after_reset_ferr", 32'(q8[0].ferr), 32'h0);
    end

    // 7-bit instance: 0x5A
    check("dbits7_quiet", 32'(q7.size()), 32'd0);
    send_frame(7, 8'h5A, 7, 1'b1);
    wait_ticks(8);
    check("dbits7_count", 32'(q7.size()), 32'd1);
    if (q7.size() == 1) begin
      check("dbits7_data", 32'(q7[0].data), 32'h5A);
      check("dbits7_ferr", 32'(q7[0].ferr), 32'h0);
      check("dbits7_len", 32'(q7[0].len), 32'd136);
    end
    check("dbits7_strobe_width", 32'(wide7), 32'd0);
    check("strobe_width_total", 32'(wide8), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
